// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared types, constants and helpers for the I/O port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // Service handshake states of the interrupt sequencer
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } io_state_e;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_PORTS   = 32;

    // Lowest set index of vec; returns 0 for an all-zero vector.
    function automatic int lowest_set(input logic [MAX_PORTS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_port_sync.sv
`default_nettype none
// ============================================================================
// Module      : io_port_sync
// Description : Multi-flop input synchroniser for one port with change detect.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_sync
    import io_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             change_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o   = stage_q[SYNC_STAGES-1];
    // Any bit difference counts; the flag lasts exactly one cycle per change
    assign change_o = (stage_q[SYNC_STAGES-1] != prev_q);

endmodule : io_port_sync
`default_nettype wire

// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_port_ctrl
// Description : Parametrised input/output port block with change interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NPORTS = 4,
    parameter int PSEL_W = $clog2(NPORTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*WIDTH-1:0]  in_p,
    output logic [NPORTS*WIDTH-1:0]  out_p,
    input  logic [PSEL_W-1:0]        sel,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     we_port,
    input  logic                     we_mask,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     irq,
    input  logic                     int_ack,
    input  logic                     int_done,
    output logic [PSEL_W-1:0]        int_id,
    output logic                     in_service
);

    if (NPORTS < 2 || NPORTS > WIDTH || NPORTS > MAX_PORTS) begin : g_param_check
        $error("io_port_ctrl: NPORTS must lie in 2..WIDTH");
    end

    logic [WIDTH-1:0]        sync_w [NPORTS];
    logic [NPORTS-1:0]       change_w;
    logic [NPORTS*WIDTH-1:0] out_q;
    logic [NPORTS-1:0]       mask_q;
    logic [NPORTS-1:0]       pending_q;
    logic [NPORTS-1:0]       pending_d;
    logic [NPORTS-1:0]       active_w;
    logic [NPORTS-1:0]       clr_w;
    logic [MAX_PORTS-1:0]    active_ext_w;
    logic [PSEL_W-1:0]       winner_w;
    logic                    grant_w;
    io_state_e               state_q;
    logic                    irq_q;
    logic                    in_service_q;
    logic [PSEL_W-1:0]       int_id_q;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        io_port_sync #(
            .WIDTH    (WIDTH)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .in_i     (in_p[g*WIDTH +: WIDTH]),
            .sync_o   (sync_w[g]),
            .change_o (change_w[g])
        );
    end

    // Out-of-range selects match no port, so the read returns zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel == PSEL_W'(i)) begin
                rd_data = sync_w[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            mask_q <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (we_port && (sel == PSEL_W'(i))) begin
                    out_q[i*WIDTH +: WIDTH] <= wr_data;
                end
            end
            if (we_mask) begin
                mask_q <= wr_data[NPORTS-1:0];
            end
        end
    end

    assign active_w = pending_q & mask_q;

    always_comb begin
        active_ext_w                = '0;
        active_ext_w[NPORTS-1:0]    = active_w;
    end

    assign winner_w = PSEL_W'(lowest_set(active_ext_w));
    assign grant_w  = (state_q == REQ) && int_ack && (|active_w);
    assign clr_w    = grant_w ? ({{(NPORTS-1){1'b0}}, 1'b1} << winner_w) : '0;

    // Set after clear so a same-cycle change event on the winner survives
    assign pending_d = (pending_q & ~clr_w) | change_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            int_id_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|active_w) begin
                        state_q <= REQ;
                        irq_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (grant_w) begin
                        state_q      <= SERVICE;
                        int_id_q     <= winner_w;
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!(|active_w)) begin
                        // Request withdrawn, e.g. by a mask write
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        state_q      <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_p      = out_q;
    assign irq        = irq_q;
    assign in_service = in_service_q;
    assign int_id     = int_id_q;

endmodule : io_port_ctrl
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_ctrl
// Description : Directed self-checking bench for io_port_ctrl (4- and 3-port).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_ctrl;

    logic        clk;
    logic        reset;

    // 4-port instance
    logic [31:0] in_p;
    logic [31:0] out_p;
    logic [1:0]  sel;
    logic [7:0]  wr_data;
    logic        we_port;
    logic        we_mask;
    logic [7:0]  rd_data;
    logic        irq;
    logic        int_ack;
    logic        int_done;
    logic [1:0]  int_id;
    logic        in_service;

    // 3-port instance for out-of-range select
    logic [23:0] in_p3;
    logic [23:0] out_p3;
    logic [1:0]  sel3;
    logic [7:0]  wr_data3;
    logic        we_port3;
    logic [7:0]  rd_data3;
    logic        irq3;
    logic [1:0]  int_id3;
    logic        in_service3;

    int n_checks;
    int n_errors;

    io_port_ctrl #(.WIDTH(8), .NPORTS(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_p       (in_p),
        .out_p      (out_p),
        .sel        (sel),
        .wr_data    (wr_data),
        .we_port    (we_port),
        .we_mask    (we_mask),
        .rd_data    (rd_data),
        .irq        (irq),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .int_id     (int_id),
        .in_service (in_service)
    );

    io_port_ctrl #(.WIDTH(8), .NPORTS(3)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .in_p       (in_p3),
        .out_p      (out_p3),
        .sel        (sel3),
        .wr_data    (wr_data3),
        .we_port    (we_port3),
        .we_mask    (1'b0),
        .rd_data    (rd_data3),
        .irq        (irq3),
        .int_ack    (1'b0),
        .int_done   (1'b0),
        .int_id     (int_id3),
        .in_service (in_service3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        in_p  = '0;
        in_p3 = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        wr_data = m;
        we_mask = 1'b1;
        tick();
        we_mask = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        in_p     = '0;
        sel      = '0;
        wr_data  = '0;
        we_port  = 1'b0;
        we_mask  = 1'b0;
        int_ack  = 1'b0;
        int_done = 1'b0;
        in_p3    = '0;
        sel3     = '0;
        wr_data3 = '0;
        we_port3 = 1'b0;
        ticks(2);

        check("reset_out_p",      out_p,      32'h0);
        check("reset_rd_data",    rd_data,    32'h0);
        check("reset_irq",        irq,        32'h0);
        check("reset_in_service", in_service, 32'h0);
        check("reset_int_id",     int_id,     32'h0);
        reset = 1'b0;
        tick();

        // Output write, plus in-range and out-of-range writes on 3-port unit
        sel = 2'd2; wr_data = 8'hA5; we_port = 1'b1;
        sel3 = 2'd1; wr_data3 = 8'h5A; we_port3 = 1'b1;
        tick();
        we_port = 1'b0;
        check("write_port2", out_p, 32'h00A5_0000);
        check("write3_port1", out_p3, 32'h0000_5A00);
        sel3 = 2'd3; wr_data3 = 8'hFF;
        tick();
        we_port3 = 1'b0;
        check("write3_sel_oob", out_p3, 32'h0000_5A00);

        in_p3 = 24'hFF_FFFF;
        ticks(3);
        check("read3_sel_oob", rd_data3, 32'h0);
        sel3 = 2'd2;
        #1;
        check("read3_port2", rd_data3, 32'hFF);

        // Read latency
        sel  = 2'd1;
        in_p = 32'h0000_3C00;
        tick();
        check("read_lat_edge1", rd_data, 32'h0);
        tick();
        check("read_lat_edge2", rd_data, 32'h3C);

        // Basic interrupt
        do_reset();
        check("rst_clears_out", out_p, 32'h0);
        write_mask(8'h02);
        in_p = 32'h0000_1100;
        ticks(3);
        check("irq_not_yet", irq, 32'h0);
        tick();
        check("irq_after_4", irq, 32'h1);
        check("no_service_in_req", in_service, 32'h0);
        pulse_ack();
        check("ack1_int_id", int_id, 32'h1);
        check("ack1_in_service", in_service, 32'h1);
        check("ack1_irq", irq, 32'h0);
        pulse_done();
        check("done1_in_service", in_service, 32'h0);
        check("done1_irq", irq, 32'h0);
        tick();
        check("done1_irq_stays", irq, 32'h0);

        // Priority and accumulation
        write_mask(8'h0F);
        in_p = in_p ^ 32'h0100_0001;
        ticks(4);
        check("prio_irq", irq, 32'h1);
        pulse_ack();
        check("prio_int_id0", int_id, 32'h0);
        in_p = in_p ^ 32'h0001_0000;
        ticks(4);
        check("accum_no_nest_irq", irq, 32'h0);
        check("accum_in_service", in_service, 32'h1);
        pulse_done();
        check("accum_done_irq_low", irq, 32'h0);
        tick();
        check("accum_irq_reassert", irq, 32'h1);
        pulse_ack();
        check("accum_int_id2", int_id, 32'h2);
        pulse_done();
        tick();
        check("accum_irq_third", irq, 32'h1);
        pulse_ack();
        check("accum_int_id3", int_id, 32'h3);
        pulse_done();
        tick();
        check("accum_drained_irq", irq, 32'h0);
        check("int_id_held", int_id, 32'h3);

        // Masking
        write_mask(8'h00);
        in_p = in_p ^ 32'h0000_0002;
        ticks(5);
        check("masked_irq", irq, 32'h0);
        write_mask(8'h01);
        check("unmask_irq_edge0", irq, 32'h0);
        tick();
        check("unmask_irq_edge1", irq, 32'h1);
        write_mask(8'h00);
        check("remask_irq_hold", irq, 32'h1);
        tick();
        check("remask_back_idle", irq, 32'h0);

        // Asynchronous reset during service
        write_mask(8'h01);
        tick();
        check("svc_req_irq", irq, 32'h1);
        pulse_ack();
        check("svc_in_service", in_service, 32'h1);
        sel = 2'd0; wr_data = 8'h77; we_port = 1'b1;
        tick();
        we_port = 1'b0;
        sel = 2'd1;
        #1;
        check("svc_out_p", out_p, 32'h0000_0077);
        check("svc_rd_data", rd_data, 32'h11);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_out_p", out_p, 32'h0);
        check("async_rst_rd_data", rd_data, 32'h0);
        check("async_rst_irq", irq, 32'h0);
        check("async_rst_in_service", in_service, 32'h0);
        check("async_rst_int_id", int_id, 32'h0);
        check("async_rst_out_p3", out_p3, 32'h0);
        tick();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_io_port_ctrl
`default_nettype wire
